// File: rtl/acc_datapath_p_if.sv
// Memory bus between the accumulator datapath (master) and a single-port memory (slave).
interface acc_datapath_p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemD;
  logic [DATA_W-1:0] MemQ;

  modport master (output MemAddr, output MemD, input MemQ);
  modport slave  (input MemAddr, input MemD, output MemQ);
endinterface

// File: rtl/acc_datapath_p.sv
// Accumulator-machine datapath: PC/MAR/IR/MDR, NACC accumulators, 8-op ALU, Z/N/C flags.
// Optional relative branching is enabled with `define DP_RELBRANCH_EN.
module acc_datapath_p #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OP_W   = 8,
  parameter int NACC   = 4,
  localparam int ACCSEL_W = $clog2(NACC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                muxPC,
  input  logic                pc_rel,
  input  logic                muxMAR,
  input  logic                muxACC,
  input  logic                loadPC,
  input  logic                loadMAR,
  input  logic                loadIR,
  input  logic                loadMDR,
  input  logic                loadACC,
  input  logic [ACCSEL_W-1:0] acc_sel,
  input  logic [2:0]          opALU,
  output logic [OP_W-1:0]     opcode,
  output logic                zflag,
  output logic                nflag,
  output logic                cflag,
  acc_datapath_p_if.master    mem
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_acc [NACC];
  logic              r_z;
  logic              r_n;
  logic              r_c;

  logic              w_sel_ok;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_alu;
  logic              w_alu_c;
  logic [DATA_W-1:0] w_wr;
  logic              w_wr_c;
  logic [ADDR_W-1:0] w_ir_addr;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_ir_addr = r_ir[ADDR_W-1:0];
  assign w_sel_ok  = int'(acc_sel) < NACC;

  always_comb begin
    w_a = '0;
    if (w_sel_ok) w_a = r_acc[acc_sel];
  end

  assign w_sum  = {1'b0, w_a} + {1'b0, r_mdr};
  assign w_diff = {1'b0, w_a} - {1'b0, r_mdr};

  always_comb begin
    w_alu   = '0;
    w_alu_c = 1'b0;
    case (opALU)
      3'b000: begin w_alu = w_sum[DATA_W-1:0];  w_alu_c = w_sum[DATA_W];  end
      3'b001: begin w_alu = w_diff[DATA_W-1:0]; w_alu_c = w_diff[DATA_W]; end
      3'b010: w_alu = w_a & r_mdr;
      3'b011: w_alu = w_a | r_mdr;
      3'b100: w_alu = w_a ^ r_mdr;
      3'b101: w_alu = ~w_a;
      3'b110: w_alu = r_mdr;
      3'b111: begin w_alu = {w_a[DATA_W-2:0], 1'b0}; w_alu_c = w_a[DATA_W-1]; end
      default: ;
    endcase
  end

  assign w_wr   = muxACC ? r_mdr : w_alu;
  assign w_wr_c = muxACC ? 1'b0  : w_alu_c;

`ifdef DP_RELBRANCH_EN
  // Offset is already ADDR_W wide, so the sign-extended add mod 2^ADDR_W is a plain add.
  always_comb begin
    w_pc_next = r_pc + 1'b1;
    if (muxPC) w_pc_next = pc_rel ? (r_pc + w_ir_addr) : w_ir_addr;
  end
`else
  logic w_unused_pc_rel;
  assign w_unused_pc_rel = pc_rel;

  always_comb begin
    w_pc_next = r_pc + 1'b1;
    if (muxPC) w_pc_next = w_ir_addr;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_mar <= '0;
      r_ir  <= '0;
      r_mdr <= '0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_c   <= 1'b0;
      for (int unsigned i = 0; i < NACC; i++) r_acc[i] <= '0;
    end else if (!hold) begin
      if (loadPC)  r_pc  <= w_pc_next;
      if (loadMAR) r_mar <= muxMAR ? w_ir_addr : r_pc;
      if (loadIR)  r_ir  <= r_mdr;
      if (loadMDR) r_mdr <= mem.MemQ;
      if (loadACC) begin
        // Out-of-range selects drop the data write but still update the flags.
        if (w_sel_ok) r_acc[acc_sel] <= w_wr;
        r_z <= (w_wr == '0);
        r_n <= w_wr[DATA_W-1];
        r_c <= w_wr_c;
      end
    end
  end

  assign opcode      = r_ir[DATA_W-1 -: OP_W];
  assign zflag       = r_z;
  assign nflag       = r_n;
  assign cflag       = r_c;
  assign mem.MemAddr = r_mar;
  assign mem.MemD    = w_a;

endmodule
